// File: rtl/alu_scheduler_if.sv
// =============================================================================
// alu_scheduler_if : request / ALU-issue / completion bundle for alu_scheduler
// Rev 1.0
// =============================================================================
`default_nettype none

interface alu_scheduler_if;
  logic       req0_valid;
  logic [4:0] req0_opcode;
  logic       req0_ready;
  logic       req1_valid;
  logic [4:0] req1_opcode;
  logic       req1_ready;
  logic       alu_enable;
  logic [4:0] alu_opcode;
  logic       done_valid;
  logic       done_id;
  logic       done_illegal;

  modport master (
    output req0_valid, req0_opcode, req1_valid, req1_opcode,
    input  req0_ready, req1_ready,
    input  alu_enable, alu_opcode, done_valid, done_id, done_illegal
  );

  modport slave (
    input  req0_valid, req0_opcode, req1_valid, req1_opcode,
    output req0_ready, req1_ready,
    output alu_enable, alu_opcode, done_valid, done_id, done_illegal
  );
endinterface

`default_nettype wire

// File: rtl/alu_scheduler.sv
// =============================================================================
// alu_scheduler : two-requester round-robin issue scheduler for a multi-cycle ALU
// Rev 1.0
// =============================================================================
`default_nettype none

module alu_scheduler #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  alu_scheduler_if.slave sch
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] C_CLS_SIMPLE = 2'd0;
  localparam logic [1:0] C_CLS_MUL    = 2'd1;
  localparam logic [1:0] C_CLS_DIV    = 2'd2;
  localparam logic [1:0] C_CLS_ILL    = 2'd3;

  localparam logic [3:0] C_MUL_M1 = 4'(MUL_LAT - 1);
  localparam logic [3:0] C_DIV_M1 = 4'(DIV_LAT - 1);

  function automatic logic [1:0] f_class(input logic [4:0] op);
    logic [1:0] cls;
    cls = C_CLS_SIMPLE;
    if (op == 5'd0 || op >= 5'd24)                      cls = C_CLS_ILL;
    else if (op == 5'd3 || op == 5'd20)                 cls = C_CLS_MUL;
    else if (op == 5'd4 || op == 5'd5 || op == 5'd21)   cls = C_CLS_DIV;
    return cls;
  endfunction

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_last;
  logic [4:0] r_op;
  logic       r_id;
  logic [1:0] r_cls;
  logic       r_alu_en;
  logic [4:0] r_alu_op;
  logic       r_done_valid;
  logic       r_done_id;
  logic       r_done_illegal;

  logic       w_grant_id;
  logic       w_accept;
  logic [4:0] w_sel_op;
  logic [1:0] w_sel_cls;
  logic [3:0] w_len_m1;

  // On a tie the requester that did not win last time gets the grant.
  assign w_grant_id = (sch.req0_valid && sch.req1_valid) ? ~r_last : sch.req1_valid;
  assign w_accept   = rst_n && (r_state == S_IDLE) && (sch.req0_valid || sch.req1_valid);
  assign w_sel_op   = w_grant_id ? sch.req1_opcode : sch.req0_opcode;
  assign w_sel_cls  = f_class(w_sel_op);

  always_comb begin
    w_len_m1 = 4'd0;
    case (w_sel_cls)
      C_CLS_MUL: w_len_m1 = C_MUL_M1;
      C_CLS_DIV: w_len_m1 = C_DIV_M1;
      default:   w_len_m1 = 4'd0;
    endcase
  end

  assign sch.req0_ready   = w_accept && !w_grant_id;
  assign sch.req1_ready   = w_accept &&  w_grant_id;
  assign sch.alu_enable   = r_alu_en;
  assign sch.alu_opcode   = r_alu_op;
  assign sch.done_valid   = r_done_valid;
  assign sch.done_id      = r_done_id;
  assign sch.done_illegal = r_done_illegal;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= 4'd0;
      r_last         <= 1'b1;
      r_op           <= 5'd0;
      r_id           <= 1'b0;
      r_cls          <= C_CLS_SIMPLE;
      r_alu_en       <= 1'b0;
      r_alu_op       <= 5'd0;
      r_done_valid   <= 1'b0;
      r_done_id      <= 1'b0;
      r_done_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op   <= w_sel_op;
            r_id   <= w_grant_id;
            r_cls  <= w_sel_cls;
            r_last <= w_grant_id;
            if (w_sel_cls == C_CLS_ILL) begin
              // Illegal opcodes never reach the ALU and complete immediately.
              r_state        <= S_DONE;
              r_done_valid   <= 1'b1;
              r_done_id      <= w_grant_id;
              r_done_illegal <= 1'b1;
            end else begin
              r_state  <= S_EXEC;
              r_alu_en <= 1'b1;
              r_alu_op <= w_sel_op;
              r_cnt    <= w_len_m1;
            end
          end
        end
        S_EXEC: begin
          if (r_cnt == 4'd0) begin
            r_state        <= S_DONE;
            r_alu_en       <= 1'b0;
            r_alu_op       <= 5'd0;
            r_done_valid   <= 1'b1;
            r_done_id      <= r_id;
            r_done_illegal <= (r_cls == C_CLS_ILL);
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          r_state        <= S_IDLE;
          r_done_valid   <= 1'b0;
          r_done_id      <= 1'b0;
          r_done_illegal <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_scheduler.sv
// =============================================================================
// tb_alu_scheduler : randomized check of alu_scheduler against a timeline model
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_alu_scheduler;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 8;
  localparam int NRUN    = 3000;
  localparam int NCYC    = NRUN + 40;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_scheduler_if u_if();

  alu_scheduler #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sch   (u_if.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Expected output timeline, one entry per cycle.
  bit       exp_en  [NCYC];
  bit [4:0] exp_op  [NCYC];
  bit       exp_dv  [NCYC];
  bit       exp_did [NCYC];
  bit       exp_dill[NCYC];
  int       free_at;
  bit       last_g;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int op_len(input logic [4:0] op);
    if (op == 5'd0 || op >= 5'd24) return 0;
    if (op inside {5'd3, 5'd20})   return MUL_LAT;
    if (op inside {5'd4, 5'd5, 5'd21}) return DIV_LAT;
    return 1;
  endfunction

  function automatic logic [4:0] rand_op();
    int sel;
    sel = $urandom_range(0, 99);
    if (sel < 20) return ($urandom_range(0, 1) == 0) ? 5'd3 : 5'd20;
    if (sel < 40) begin
      case ($urandom_range(0, 2))
        0:       return 5'd4;
        1:       return 5'd5;
        default: return 5'd21;
      endcase
    end
    if (sel < 55) return ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(24, 31));
    return 5'($urandom_range(1, 23));
  endfunction

  initial begin
    bit v0, v1, e_r0, e_r1, g;
    logic [4:0] op;
    int len;

    rst_n            = 1'b0;
    u_if.req0_valid  = 1'b0;
    u_if.req0_opcode = 5'd0;
    u_if.req1_valid  = 1'b0;
    u_if.req1_opcode = 5'd0;
    free_at          = 0;
    last_g           = 1'b1;
    repeat (3) @(posedge clk);

    for (cyc = 0; cyc < NRUN; cyc++) begin
      @(posedge clk);
      #1;
      rst_n            = ($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1;
      u_if.req0_valid  = ($urandom_range(0, 9) < 7);
      u_if.req1_valid  = ($urandom_range(0, 9) < 7);
      u_if.req0_opcode = rand_op();
      u_if.req1_opcode = rand_op();
      #4;

      chk("alu_enable", 32'(u_if.alu_enable), 32'(exp_en[cyc]));
      chk("alu_opcode", 32'(u_if.alu_opcode), 32'(exp_op[cyc]));
      chk("done_valid", 32'(u_if.done_valid), 32'(exp_dv[cyc]));
      if (exp_dv[cyc]) begin
        chk("done_id",      32'(u_if.done_id),      32'(exp_did[cyc]));
        chk("done_illegal", 32'(u_if.done_illegal), 32'(exp_dill[cyc]));
      end

      v0   = u_if.req0_valid;
      v1   = u_if.req1_valid;
      e_r0 = 1'b0;
      e_r1 = 1'b0;
      if (rst_n && cyc >= free_at) begin
        if (v0 && v1) begin
          e_r0 = (last_g == 1'b1);
          e_r1 = (last_g == 1'b0);
        end else begin
          e_r0 = v0;
          e_r1 = v1;
        end
      end
      chk("req0_ready", 32'(u_if.req0_ready), 32'(e_r0));
      chk("req1_ready", 32'(u_if.req1_ready), 32'(e_r1));

      if (!rst_n) begin
        for (int k = cyc + 1; k < NCYC && k <= cyc + 20; k++) begin
          exp_en[k]   = 1'b0;
          exp_op[k]   = 5'd0;
          exp_dv[k]   = 1'b0;
          exp_did[k]  = 1'b0;
          exp_dill[k] = 1'b0;
        end
        free_at = cyc + 1;
        last_g  = 1'b1;
      end else if (e_r0 || e_r1) begin
        g      = e_r1;
        op     = g ? u_if.req1_opcode : u_if.req0_opcode;
        len    = op_len(op);
        last_g = g;
        for (int k = 1; k <= len; k++) begin
          exp_en[cyc + k] = 1'b1;
          exp_op[cyc + k] = op;
        end
        exp_dv[cyc + len + 1]   = 1'b1;
        exp_did[cyc + len + 1]  = g;
        exp_dill[cyc + len + 1] = (len == 0);
        free_at = cyc + len + 2;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
